// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MD_BUSY = 2'd1} state_t;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;
  localparam int MD_TIMEOUT_DEFAULT = 40;
endpackage

// File: rtl/pipe_perf_counters.sv
// pipe_perf_counters: wrapping event counters (clock, reset, stall/flush/busy strobes in; stall_cycles/flush_count/md_cycles out)
module pipe_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] md_cycles
);
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      md_cycles    <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(stall);
      flush_count  <= flush_count + CNT_W'(flush);
      md_cycles    <= md_cycles + CNT_W'(busy);
    end
  end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer (hazard/branch/multdiv in; latch enables, flush/bubbles, md_start/md_abort, ctrl_state, perf counters out; counters built under PIPE_PERF_CNT_EN)
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             haz_load_use,
  input  logic             branch_taken,
  input  logic             md_insn_dx,
  input  logic             md_ready,
  output logic             md_start,
  output logic             md_abort,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] md_cycles
);
  localparam int TW = $clog2(MD_TIMEOUT + 1);
  state_t state;
  logic [TW-1:0] tmo;
  logic busy, tmo_hit, hold, br, lu;
  assign busy    = state == MD_BUSY;
  assign tmo_hit = tmo == TW'(MD_TIMEOUT);
  // still waiting on multdiv: neither a result nor the timeout this cycle
  assign hold      = busy && !md_ready && !tmo_hit;
  assign br        = !reset && !busy && branch_taken;
  assign md_start  = !reset && !busy && !branch_taken && md_insn_dx;
  assign lu        = !reset && !busy && !branch_taken && !md_insn_dx && haz_load_use;
  assign md_abort  = !reset && busy && tmo_hit && !md_ready;
  assign pc_en     = !reset && !md_start && !lu && !hold;
  assign fd_en     = pc_en;
  assign dx_en     = !reset && !md_start && !hold;
  assign xm_en     = !reset;
  assign mw_en     = !reset;
  assign fd_flush  = reset || br;
  assign dx_bubble = reset || br || lu;
  assign xm_bubble = reset || md_start || hold;
  assign ctrl_state = state;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      tmo   <= '0;
    end else if (md_start) begin
      state <= MD_BUSY;
      tmo   <= TW'(1);
    end else if (busy) begin
      state <= hold ? MD_BUSY : RUN;
      tmo   <= tmo + TW'(1);
    end
  end
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clock(clock),
    .reset(reset),
    .stall(!reset && !pc_en),
    .flush(br),
    .busy(!reset && busy),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count),
    .md_cycles(md_cycles)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
  assign md_cycles    = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  localparam int CW = 32;
  // expected vector: {md_start, md_abort, pc, fd, dx, xm, mw en, fd_flush, dx_bubble, xm_bubble, state[1:0]}
  localparam logic [11:0] E_RST  = 12'b0_0_00000_111_00;
  localparam logic [11:0] E_RSTB = 12'b0_0_00000_111_01;
  localparam logic [11:0] E_RUN  = 12'b0_0_11111_000_00;
  localparam logic [11:0] E_BR   = 12'b0_0_11111_110_00;
  localparam logic [11:0] E_LU   = 12'b0_0_00111_010_00;
  localparam logic [11:0] E_MDS  = 12'b1_0_00011_001_00;
  localparam logic [11:0] E_BUSY = 12'b0_0_00011_001_01;
  localparam logic [11:0] E_DONE = 12'b0_0_11111_000_01;
  localparam logic [11:0] E_ABT  = 12'b0_1_11111_000_01;
  logic clock = 0, reset = 1, haz_load_use = 0, branch_taken = 0, md_insn_dx = 0, md_ready = 0;
  logic md_start, md_abort, pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble;
  logic [1:0] ctrl_state;
  logic [CW-1:0] stall_cycles, flush_count, md_cycles;
  logic [CW-1:0] m_stall = 0, m_flush = 0, m_md = 0;
  logic [11:0] sb[$];
  int n_assert = 0, n_fail = 0;
  pipeline_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .haz_load_use(haz_load_use), .branch_taken(branch_taken),
    .md_insn_dx(md_insn_dx), .md_ready(md_ready), .md_start(md_start), .md_abort(md_abort),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .md_cycles(md_cycles)
  );
  always #5 clock = ~clock;
  task automatic cyc(input string tag, input logic r, b, m, l, y, input logic [11:0] e);
    logic [11:0] got, exp;
    reset = r; branch_taken = b; md_insn_dx = m; haz_load_use = l; md_ready = y;
    sb.push_back(e);
    @(negedge clock);
    got = {md_start, md_abort, pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble, ctrl_state};
    exp = sb.pop_front();
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
    if (r) begin
      m_stall = 0; m_flush = 0; m_md = 0;
    end else begin
      m_stall += CW'(!exp[9]);
      m_flush += CW'(b && exp[1:0] == 2'd0);
      m_md    += CW'(exp[1:0] == 2'd1);
    end
    @(posedge clock); #1;
  endtask
  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] model);
    logic [CW-1:0] exp;
`ifdef PIPE_PERF_CNT_EN
    exp = model;
`else
    exp = '0;
`endif
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_cnt(input string tag);
    chk({tag, "_stall"}, stall_cycles, m_stall);
    chk({tag, "_flush"}, flush_count, m_flush);
    chk({tag, "_md"}, md_cycles, m_md);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 1, 0, 0, 0, 0, E_RST);
    chk_cnt("after_reset");
    cyc("idle", 0, 0, 0, 0, 0, E_RUN);
    cyc("ready_in_run", 0, 0, 0, 0, 1, E_RUN);
    chk_cnt("idle");
    cyc("load_use", 0, 0, 0, 1, 0, E_LU);
    cyc("after_lu", 0, 0, 0, 0, 0, E_RUN);
    chk_cnt("lu");
    cyc("branch_lu", 0, 1, 0, 1, 0, E_BR);
    cyc("after_br", 0, 0, 0, 0, 0, E_RUN);
    chk_cnt("branch");
    cyc("md_start", 0, 0, 1, 0, 0, E_MDS);
    for (int i = 1; i < 16; i++) cyc("md_wait", 0, i == 5, 1, i == 7, 0, E_BUSY);
    cyc("md_done", 0, 0, 1, 0, 1, E_DONE);
    cyc("after_md", 0, 0, 0, 0, 0, E_RUN);
    chk_cnt("md16");
    cyc("md_start_to", 0, 0, 1, 0, 0, E_MDS);
    for (int i = 1; i < 40; i++) cyc("md_wait_to", 0, 0, 1, 0, 0, E_BUSY);
    cyc("md_abort", 0, 0, 1, 0, 0, E_ABT);
    cyc("after_abort", 0, 0, 0, 0, 0, E_RUN);
    chk_cnt("timeout");
    cyc("md_start_r40", 0, 0, 1, 0, 0, E_MDS);
    for (int i = 1; i < 40; i++) cyc("md_wait_r40", 0, 0, 1, 0, 0, E_BUSY);
    cyc("md_ready_40", 0, 0, 1, 0, 1, E_DONE);
    cyc("after_r40", 0, 0, 0, 0, 0, E_RUN);
    chk_cnt("ready40");
    cyc("md_start_rst", 0, 0, 1, 0, 0, E_MDS);
    for (int i = 1; i <= 5; i++) cyc("md_wait_rst", 0, 0, 1, 0, 0, E_BUSY);
    cyc("reset_busy", 1, 0, 1, 0, 0, E_RSTB);
    cyc("after_rst", 0, 0, 0, 0, 0, E_RUN);
    chk_cnt("mid_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
